// File: rtl/conq_trace_recorder.sv
// rtl/conq_trace_recorder.sv - change-compressed trace capture buffer with valid/ready readback
//
// Samples obs_data_i every cycle while recording and stores {timestamp, data}
// records whenever the observation changes, on the first cycle of a session,
// and when the timestamp reaches all-ones (so wrapped time can be rebuilt).
// After capture ends, the records are streamed out oldest-first with no bubbles
// between accepted records.
//
// Optional build macro: CONQ_WRAP_EN
//   undefined : capture stops (state DONE) as soon as the buffer is full
//   defined   : circular buffer, oldest record overwritten, capture runs until stop
//
// Ports:
//   sys_clk_i     clock, all logic on the rising edge
//   sys_rst_i     synchronous active-high reset
//   obs_data_i    observed DUT output vector
//   arm_i         pulse: start a new capture session (aborts anything in progress)
//   stop_i        pulse: end capture (only honoured while recording)
//   rd_ready_i    reader accepts the presented record
//   rd_valid_o    record presented on rd_data_o / rd_ts_o
//   rd_data_o     recorded observation
//   rd_ts_o       cycle stamp of the record
//   rd_last_o     presented record is the final one
//   recording_o   high while capturing
//   full_o        buffer holds DEPTH records
//   count_o       number of records stored

module conq_trace_recorder #(
    parameter int DATA_W = 11,
    parameter int DEPTH  = 256,
    parameter int TS_W   = 16
) (
    input  logic                       sys_clk_i,
    input  logic                       sys_rst_i,
    input  logic [DATA_W-1:0]          obs_data_i,
    input  logic                       arm_i,
    input  logic                       stop_i,
    input  logic                       rd_ready_i,
    output logic                       rd_valid_o,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic [TS_W-1:0]            rd_ts_o,
    output logic                       rd_last_o,
    output logic                       recording_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = TS_W + DATA_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REC,
        S_DONE,
        S_READ
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     rd_idx_q, rd_idx_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              force_q, force_d;
    logic [RW-1:0]     rd_word_q;

    logic              we;
    logic              re;
    logic [AW-1:0]     raddr;
    logic              qualify;
    logic              is_last;

    logic [RW-1:0]     mem_q [DEPTH];

    assign qualify = force_q || (obs_data_i != prev_q) || (ts_q == {TS_W{1'b1}});
    assign is_last = (rd_idx_q == count_q - CW'(1));

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        rd_idx_d = rd_idx_q;
        ts_d     = ts_q;
        prev_d   = prev_q;
        force_d  = force_q;
        we       = 1'b0;
        re       = 1'b0;
        raddr    = rptr_q;

        // arm always wins: discard whatever is in progress and start clean.
        if (arm_i) begin
            state_d  = S_REC;
            wptr_d   = '0;
            rptr_d   = '0;
            count_d  = '0;
            rd_idx_d = '0;
            ts_d     = '0;
            force_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                end

                S_REC: begin
                    prev_d = obs_data_i;
                    ts_d   = ts_q + TS_W'(1);
                    if (qualify) begin
                        we      = 1'b1;
                        wptr_d  = wptr_q + AW'(1);
                        force_d = 1'b0;
`ifdef CONQ_WRAP_EN
                        if (count_q != DEPTH_C) begin
                            count_d = count_q + CW'(1);
                        end
`else
                        count_d = count_q + CW'(1);
                        if (count_q == DEPTH_C - CW'(1)) begin
                            state_d = S_DONE;
                        end
`endif
                    end
                    if (stop_i) begin
                        state_d = S_DONE;
                    end
                end

                S_DONE: begin
                    if (count_q != '0) begin
                        // Oldest record sits count entries behind the write
                        // pointer; a full buffer wraps to the write pointer itself.
                        raddr    = wptr_q - count_q[AW-1:0];
                        re       = 1'b1;
                        rptr_d   = raddr;
                        rd_idx_d = '0;
                        state_d  = S_READ;
                    end
                end

                S_READ: begin
                    if (rd_ready_i) begin
                        if (is_last) begin
                            state_d = S_IDLE;
                        end else begin
                            // Prefetch the next entry on the accepting edge so
                            // the following cycle already presents it.
                            raddr    = rptr_q + AW'(1);
                            re       = 1'b1;
                            rptr_d   = raddr;
                            rd_idx_d = rd_idx_q + CW'(1);
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q  <= S_IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rd_idx_q <= '0;
            ts_q     <= '0;
            prev_q   <= '0;
            force_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rd_idx_q <= rd_idx_d;
            ts_q     <= ts_d;
            prev_q   <= prev_d;
            force_q  <= force_d;
        end
    end

    // Storage array: write port only, no reset so it maps onto block RAM.
    always_ff @(posedge sys_clk_i) begin
        if (we && !sys_rst_i) begin
            mem_q[wptr_q] <= {ts_q, obs_data_i};
        end
    end

    // Registered read port; only updated on a load so the presented record
    // holds steady while the reader stalls.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            rd_word_q <= '0;
        end else if (re) begin
            rd_word_q <= mem_q[raddr];
        end
    end

    assign rd_valid_o  = (state_q == S_READ);
    assign rd_last_o   = (state_q == S_READ) && is_last;
    assign rd_data_o   = rd_word_q[DATA_W-1:0];
    assign rd_ts_o     = rd_word_q[RW-1:DATA_W];
    assign recording_o = (state_q == S_REC);
    assign full_o      = (count_q == DEPTH_C);
    assign count_o     = count_q;

endmodule

// File: doc/conq_trace_recorder.md
Name: conq_trace_recorder

Overview:
- Capture-side counterpart to the opcode stimulus player: samples DUT observable outputs every sys_clk and writes change-compressed {timestamp, data} records into an internal buffer.
- Records are read back afterwards through a valid/ready port, either for comparison against the expected response or for dumping by the bench.
- Sits beside the DUT in the Conquest harness.
- The stimulus player writes the DUT inputs; this block reads the DUT outputs.

Parameters:
DATA_W, 11, width of the sampled observation vector (matches opcode width)
DEPTH, 256, number of trace records (power of two)
TS_W, 16, width of the cycle timestamp counter

Ports:
sys_clk  in  1  clock; all logic on rising edge
sys_rst  in  1  synchronous reset, active-high
obs_data  in  DATA_W  DUT output vector sampled each cycle
arm  in  1  one-cycle pulse; starts a new capture session
stop  in  1  one-cycle pulse; ends capture
rd_ready  in  1  reader accepts current record
rd_valid  out  1  record available on rd_*
rd_data  out  DATA_W  recorded observation
rd_ts  out  TS_W  cycle stamp of record
rd_last  out  1  marks final record
recording  out  1  high while in REC
full  out  1  buffer holds DEPTH records
count  out  $clog2(DEPTH)+1  records stored

Behaviour:
- Reset values:
  - state=IDLE.
  - rd_valid=0, rd_data=0, rd_ts=0, rd_last=0.
  - recording=0, full=0, count=0.
  - Write pointer, read pointer and ts counter all 0.
  - prev_data=0.
- States: IDLE, REC, DONE, READ.
- IDLE:
  - arm -> REC.
  - Clears count, pointers and ts.
  - Sets force_store.
- REC:
  - ts increments by 1 each cycle, starting at 0 on the first REC cycle.
  - A record {ts, obs_data} is written when any of these holds:
    - force_store=1;
    - obs_data != prev_data;
    - ts == all-ones (wrap marker, so elapsed time stays reconstructible).
  - prev_data <= obs_data every REC cycle.
  - force_store clears after the first write.
  - ts wraps from all-ones to 0.
- Write latency: a change sampled at edge N is stored at edge N with ts of cycle N.
- Full:
  - count==DEPTH -> full=1.
  - Further writes are dropped.
  - State -> DONE on the same edge.
  - See CONQ_WRAP_EN for the alternative.
- stop in REC -> DONE. A record qualifying on the same cycle as stop is still written.
- arm while in REC restarts the session (same as IDLE+arm); the old contents are discarded.
- DONE:
  - recording=0.
  - count==0 -> stay in DONE with rd_valid=0.
  - Otherwise load the first record and go to READ.
- READ:
  - rd_valid=1 with registered rd_data/rd_ts.
  - rd_last=1 when this is the final stored record.
  - Transfer occurs on rd_valid&rd_ready.
  - The next record is presented on the following cycle (1-cycle bubble is allowed; zero-bubble is preferred).
  - rd_* stay stable while rd_valid&!rd_ready.
  - After the transfer with rd_last=1: rd_valid=0, state -> IDLE. count is retained until the next arm.
- arm in DONE/READ aborts readout: rd_valid=0 and a new session starts.
- sys_rst at any time overrides everything and returns all outputs to their reset values.
- stop outside REC is ignored.
- rd_ready outside READ is ignored.
- Buffer: inferred synchronous single-port-per-side RAM, DEPTH x (TS_W+DATA_W).

Optional Feature:
- Macro: CONQ_WRAP_EN.
- Defined:
  - Buffer is circular; when full, a new write overwrites the oldest record.
  - Read pointer start = write pointer, so readout covers the last DEPTH records in time order.
  - count saturates at DEPTH.
  - full stays 1 and recording continues until stop.
- Undefined: stop-on-full as described in Behaviour.

Test Plan:
- Reset, then arm; obs_data held 11'h000 for 10 cycles, then stop -> exactly 1 record {ts=0, data=0x000}; rd_last=1; count=1.
- arm; obs_data = 0x005 at ts 0, 0x405 at ts 3, 0x005 at ts 7; stop at ts 9 -> 3 records: (0,0x005), (3,0x405), (7,0x005); rd_last only on the third.
- TS_W=4, constant obs_data for 40 cycles -> records at ts 0, 15 (x2 wraps), count=3; timestamps monotonic modulo 16.
- DEPTH=8, obs_data toggles every cycle -> full=1 after 8 writes; state DONE; 8 records read back (CONQ_WRAP_EN undefined). Same stimulus with CONQ_WRAP_EN for 20 cycles -> the last 8 values in order, full=1.
- Readout with rd_ready held low 5 cycles, then pulsed -> rd_data/rd_ts stable while stalled; one record per accepted handshake; no loss or duplication.
- sys_rst asserted mid-READ -> next edge: rd_valid=0, count=0, recording=0; a subsequent arm starts a clean session.
